// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage between a combinational program ROM and the
//                decoder. Drives the ROM address from the PC, joins
//                opcode+immediate pairs into one packet, and presents packets
//                over a valid/ready handshake. Execute-stage redirects flush
//                any in-flight fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter logic [9:0]  IMM_SRC    = 10'h3A0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_word,
    output logic [15:0] ins_imm,
    output logic        ins_has_imm,
    output logic [15:0] ins_pc
);

    // OP: next ROM word is an opcode; IMM: next ROM word is the immediate
    localparam logic [0:0] c_ST_OP  = 1'b0;
    localparam logic [0:0] c_ST_IMM = 1'b1;

    logic [0:0]  r_st;
    logic [0:0]  w_st_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_op_word;
    logic [15:0] r_op_pc;
    logic        r_valid;
    logic [15:0] r_word;
    logic [15:0] r_imm;
    logic        r_has_imm;
    logic [15:0] r_ins_pc;

    logic        w_or_free;
    logic        w_two_word;
    logic        w_load_or;
    logic        w_adv;
    logic        w_latch_op;

    // The output register can take a new packet when empty or being drained
    assign w_or_free  = !r_valid || ins_ready;

    // Words whose operand lives in the following ROM word
    assign w_two_word = (rom_data[9:0] == IMM_SRC) ||
                        (rom_data[15:12] == 4'hE) ||
                        (rom_data[15:12] == 4'hD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st <= c_ST_OP;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Next-state logic; a redirect always restarts on an opcode word
    always_comb begin
        w_st_nxt = r_st;
        if (branch_en) begin
            w_st_nxt = c_ST_OP;
        end else if (w_or_free) begin
            case (r_st)
                c_ST_OP:  w_st_nxt = w_two_word ? c_ST_IMM : c_ST_OP;
                c_ST_IMM: w_st_nxt = c_ST_OP;
                default:  w_st_nxt = c_ST_OP;
            endcase
        end
    end

    // FSM controls; a redirect cancels the load and PC advance of its cycle
    always_comb begin
        w_adv      = 1'b0;
        w_load_or  = 1'b0;
        w_latch_op = 1'b0;
        if (!branch_en && w_or_free) begin
            w_adv = 1'b1;
            case (r_st)
                c_ST_OP: begin
                    w_load_or  = !w_two_word;
                    w_latch_op = w_two_word;
                end
                c_ST_IMM: w_load_or = 1'b1;
                default: begin
                    w_load_or  = 1'b0;
                    w_latch_op = 1'b0;
                end
            endcase
        end
    end

    // Program counter: redirect, advance (wraps at 16 bits) or hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_ADDR;
        end else if (branch_en) begin
            r_pc <= branch_target;
        end else if (w_adv) begin
            r_pc <= r_pc + 16'h0001;
        end
    end

    // Holds the opcode half of a two-word instruction until its immediate arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_word <= 16'h0000;
            r_op_pc   <= 16'h0000;
        end else if (w_latch_op) begin
            r_op_word <= rom_data;
            r_op_pc   <= r_pc;
        end
    end

    // Output register: load a packet, drain on acceptance, or flush on redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_word    <= 16'h0000;
            r_imm     <= 16'h0000;
            r_has_imm <= 1'b0;
            r_ins_pc  <= 16'h0000;
        end else if (branch_en) begin
            r_valid <= 1'b0;
        end else if (w_load_or) begin
            r_valid <= 1'b1;
            if (r_st == c_ST_IMM) begin
                r_word    <= r_op_word;
                r_imm     <= rom_data;
                r_has_imm <= 1'b1;
                r_ins_pc  <= r_op_pc;
            end else begin
                r_word    <= rom_data;
                r_imm     <= 16'h0000;
                r_has_imm <= 1'b0;
                r_ins_pc  <= r_pc;
            end
        end else if (r_valid && ins_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rom_addr    = r_pc;
    assign ins_valid   = r_valid;
    assign ins_word    = r_word;
    assign ins_imm     = r_imm;
    assign ins_has_imm = r_has_imm;
    assign ins_pc      = r_ins_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch with a ROM model
//                and a packet scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] imm;
        logic        has_imm;
        logic [15:0] pc;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [15:0] ins_word;
    logic [15:0] ins_imm;
    logic        ins_has_imm;
    logic [15:0] ins_pc;

    logic        reset2 = 1'b1;
    logic [15:0] rom_addr2;
    logic [15:0] rom_data2;
    logic        ins_valid2;
    logic        ins_ready2 = 1'b1;
    logic [15:0] ins_word2;
    logic [15:0] ins_imm2;
    logic        ins_has_imm2;
    logic [15:0] ins_pc2;

    logic [15:0] rom [0:65535];
    pkt_t        exp_q[$];
    pkt_t        obs_q[$];
    pkt_t        e;
    pkt_t        o;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    instruction_fetch dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .branch_en(branch_en), .branch_target(branch_target),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
        .ins_imm(ins_imm), .ins_has_imm(ins_has_imm), .ins_pc(ins_pc)
    );

    instruction_fetch #(.RESET_ADDR(16'hFFFF)) dut2 (
        .clk(clk), .reset(reset2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .branch_en(1'b0), .branch_target(16'h0000),
        .ins_valid(ins_valid2), .ins_ready(ins_ready2), .ins_word(ins_word2),
        .ins_imm(ins_imm2), .ins_has_imm(ins_has_imm2), .ins_pc(ins_pc2)
    );

    // Record every packet the decoder accepts
    always @(negedge clk) begin
        if (!reset && ins_valid && ins_ready)
            obs_q.push_back({ins_word, ins_imm, ins_has_imm, ins_pc});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({rom_addr, ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%h v=%b w=%h i=%h h=%b pc=%h, want all zero",
                     rom_addr, ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc);
        end
    endtask

    task automatic test_first_fetch();
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({16'h2202, 16'h0000, 1'b0, 16'h0000});
        exp_q.push_back({16'h0008, 16'h0000, 1'b0, 16'h0001});
        exp_q.push_back({16'hC800, 16'h0000, 1'b0, 16'h0002});
        reset = 1'b0;
        ins_ready = 1'b1;
        step();
        n_cmp++;
        if ({ins_valid, ins_word, ins_has_imm, ins_pc} !== {1'b1, 16'h2202, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL first_latency: got v=%b w=%h h=%b pc=%h, want v=1 w=2202 h=0 pc=0000",
                     ins_valid, ins_word, ins_has_imm, ins_pc);
        end
        step();
        n_cmp++;
        if ({ins_word, ins_pc} !== {16'h0008, 16'h0001}) begin
            n_fail++;
            $display("FAIL second_word: got w=%h pc=%h, want w=0008 pc=0001", ins_word, ins_pc);
        end
        step();
        step();
        ins_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL first_pkt: got none, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL first_pkt: got %h, want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_two_word();
        rom[16'h0036] = 16'h13A0;
        rom[16'h0037] = 16'h30D4;
        exp_q.delete();
        exp_q.push_back({16'h13A0, 16'h30D4, 1'b1, 16'h0036});
        exp_q.push_back({16'hC800, 16'h0000, 1'b0, 16'h0038});
        branch_en = 1'b1;
        branch_target = 16'h0036;
        ins_ready = 1'b1;
        step();
        branch_en = 1'b0;
        obs_q.delete();
        step();
        step();
        n_cmp++;
        if ({ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc} !==
            {1'b1, 16'h13A0, 16'h30D4, 1'b1, 16'h0036}) begin
            n_fail++;
            $display("FAIL two_word_latency: got v=%b w=%h i=%h h=%b pc=%h, want v=1 w=13A0 i=30D4 h=1 pc=0036",
                     ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc);
        end
        step();
        step();
        ins_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL two_word_pkt: got none, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL two_word_pkt: got %h, want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_stall();
        rom[16'h0040] = 16'h1111;
        rom[16'h0041] = 16'h2222;
        rom[16'h0042] = 16'h3333;
        rom[16'h0043] = 16'h4444;
        exp_q.delete();
        exp_q.push_back({16'h1111, 16'h0000, 1'b0, 16'h0040});
        exp_q.push_back({16'h2222, 16'h0000, 1'b0, 16'h0041});
        exp_q.push_back({16'h3333, 16'h0000, 1'b0, 16'h0042});
        branch_en = 1'b1;
        branch_target = 16'h0040;
        ins_ready = 1'b0;
        step();
        branch_en = 1'b0;
        obs_q.delete();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc, rom_addr} !==
                {1'b1, 16'h1111, 16'h0000, 1'b0, 16'h0040, 16'h0041}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b w=%h i=%h h=%b pc=%h addr=%h, want v=1 w=1111 i=0000 h=0 pc=0040 addr=0041",
                         i, ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc, rom_addr);
            end
        end
        ins_ready = 1'b1;
        step();
        n_cmp++;
        if ({ins_valid, ins_word, ins_pc} !== {1'b1, 16'h2222, 16'h0041}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b w=%h pc=%h, want v=1 w=2222 pc=0041",
                     ins_valid, ins_word, ins_pc);
        end
        step();
        step();
        ins_ready = 1'b0;
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d packets, want 3", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL stall_pkt: got none, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL stall_pkt: got %h, want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_branch_in_imm();
        rom[16'h0026] = 16'hE401;
        rom[16'h0027] = 16'h5555;
        rom[16'h0029] = 16'hE005;
        rom[16'h002A] = 16'h0011;
        exp_q.delete();
        exp_q.push_back({16'hE005, 16'h0011, 1'b1, 16'h0029});
        exp_q.push_back({16'hC800, 16'h0000, 1'b0, 16'h002B});
        ins_ready = 1'b1;
        branch_en = 1'b1;
        branch_target = 16'h0026;
        step();
        branch_en = 1'b0;
        obs_q.delete();
        step();
        n_cmp++;
        if ({ins_valid, rom_addr} !== {1'b0, 16'h0027}) begin
            n_fail++;
            $display("FAIL imm_wait: got v=%b addr=%h, want v=0 addr=0027", ins_valid, rom_addr);
        end
        branch_en = 1'b1;
        branch_target = 16'h0029;
        step();
        branch_en = 1'b0;
        n_cmp++;
        if ({ins_valid, rom_addr} !== {1'b0, 16'h0029}) begin
            n_fail++;
            $display("FAIL imm_flush: got v=%b addr=%h, want v=0 addr=0029", ins_valid, rom_addr);
        end
        step();
        step();
        step();
        step();
        ins_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL imm_branch_pkt: got none, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL imm_branch_pkt: got %h, want %h", o, e);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        rom[16'hFFFF] = 16'h1234;
        step();
        n_cmp++;
        if ({rom_addr2, ins_valid2} !== {16'hFFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_reset: got addr=%h v=%b, want addr=FFFF v=0", rom_addr2, ins_valid2);
        end
        reset2 = 1'b0;
        step();
        n_cmp++;
        if ({ins_valid2, ins_word2, ins_pc2, rom_addr2} !== {1'b1, 16'h1234, 16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_first: got v=%b w=%h pc=%h addr=%h, want v=1 w=1234 pc=FFFF addr=0000",
                     ins_valid2, ins_word2, ins_pc2, rom_addr2);
        end
        step();
        n_cmp++;
        if ({ins_valid2, ins_word2, ins_pc2} !== {1'b1, 16'h2202, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_next: got v=%b w=%h pc=%h, want v=1 w=2202 pc=0000",
                     ins_valid2, ins_word2, ins_pc2);
        end
    endtask

    task automatic test_reset_mid();
        // Stalled packet in the output register, with a redirect in the same cycle
        branch_en = 1'b1;
        branch_target = 16'h0040;
        reset = 1'b1;
        step();
        n_cmp++;
        if ({ins_valid, rom_addr, ins_word, ins_pc} !== {1'b0, 16'h0000, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_stalled: got v=%b addr=%h w=%h pc=%h, want v=0 addr=0000 w=0000 pc=0000",
                     ins_valid, rom_addr, ins_word, ins_pc);
        end
        // Reach the immediate-wait state, then reset
        rom[16'h0050] = 16'hD000;
        rom[16'h0051] = 16'h7777;
        reset = 1'b0;
        branch_target = 16'h0050;
        step();
        branch_en = 1'b0;
        step();
        n_cmp++;
        if ({ins_valid, rom_addr} !== {1'b0, 16'h0051}) begin
            n_fail++;
            $display("FAIL reset_imm_setup: got v=%b addr=%h, want v=0 addr=0051", ins_valid, rom_addr);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({ins_valid, rom_addr} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_imm: got v=%b addr=%h, want v=0 addr=0000", ins_valid, rom_addr);
        end
        exp_q.delete();
        exp_q.push_back({16'h2202, 16'h0000, 1'b0, 16'h0000});
        exp_q.push_back({16'h0008, 16'h0000, 1'b0, 16'h0001});
        reset = 1'b0;
        ins_ready = 1'b1;
        obs_q.delete();
        step();
        step();
        step();
        ins_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_mid_pkt: got none, want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reset_mid_pkt: got %h, want %h", o, e);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 16'hC800;
        rom[16'h0000] = 16'h2202;
        rom[16'h0001] = 16'h0008;
        test_reset();
        test_first_fetch();
        test_two_word();
        test_stall();
        test_branch_in_imm();
        test_pc_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
